// File: rtl/riscv_pkg.sv
// Shared register-file types for the writeback-side blocks.
package riscv_pkg;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] xlen_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  typedef struct packed {
    logic      en;
    reg_addr_t addr;
    xlen_t     data;
  } rf_wr_t;

  // Index width for an N-entry selector; never zero so a 1-entry picker still has a port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/riscv_rr_pick.sv
// Round-robin picker: first set request at or above ptr_i, wrapping around.
// Purely combinational; the owner keeps and advances the pointer.
module riscv_rr_pick
  import riscv_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]            req_i,
  input  logic [idx_width(N)-1:0] ptr_i,
  output logic [N-1:0]            gnt_o,
  output logic [idx_width(N)-1:0] idx_o,
  output logic                    any_o
);

  localparam int IW = idx_width(N);
  localparam int JW = IW + 1;

  always_comb begin : search
    logic [JW-1:0] j;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = '0;
    for (int i = 0; i < N; i++) begin
      j = {1'b0, ptr_i} + JW'(i);
      if (j >= JW'(N)) begin
        j = j - JW'(N);
      end
      if (!any_o && req_i[j[IW-1:0]]) begin
        gnt_o[j[IW-1:0]] = 1'b1;
        idx_o            = j[IW-1:0];
        any_o            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/riscv_rf_wr_arb.sv
// Register-file write-port arbiter: writeback stream by default, round-robin aux sources
// with a starvation override. Optional grant counters under `RISCV_WARB_STATS_EN.
module riscv_rf_wr_arb
  import riscv_pkg::*;
#(
  parameter int N_AUX      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  wb_valid_i,
  output logic                  wb_ready_o,
  input  logic [4:0]            wb_rd_addr_i,
  input  logic [31:0]           wb_rd_data_i,
  input  logic [N_AUX-1:0]      aux_valid_i,
  output logic [N_AUX-1:0]      aux_ready_o,
  input  logic [5*N_AUX-1:0]    aux_rd_addr_i,
  input  logic [32*N_AUX-1:0]   aux_rd_data_i,
  output logic                  rf_w_enable_o,
  output logic [4:0]            rf_w_addr_o,
  output logic [31:0]           rf_w_data_o,
  output logic [4:0]            hz_rd_addr_o,
  output logic [31:0]           stat_wb_cnt_o,
  output logic [31:0]           stat_aux_cnt_o,
  output logic [31:0]           stat_force_cnt_o
);

  localparam int         IW         = idx_width(N_AUX);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [3:0]    starve_cnt_q, starve_cnt_d;
  rf_wr_t        rf_q, rf_d;

  reg_addr_t     aux_addr [N_AUX];
  xlen_t         aux_data [N_AUX];
  logic [N_AUX-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             aux_any;

  logic      force_win;
  logic      wb_grant;
  logic      aux_grant;
  reg_addr_t sel_addr;
  xlen_t     sel_data;

  for (genvar gi = 0; gi < N_AUX; gi++) begin : g_unpack
    assign aux_addr[gi] = aux_rd_addr_i[5*gi +: 5];
    assign aux_data[gi] = aux_rd_data_i[32*gi +: 32];
  end

  riscv_rr_pick #(.N(N_AUX)) u_pick (
    .req_i (aux_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (aux_any)
  );

  always_comb begin
    force_win = aux_any && (starve_cnt_q == STARVE_LIM);
    // Nothing is accepted while reset is held, so sources keep their results.
    wb_grant  = !reset_i && wb_valid_i && !force_win;
    aux_grant = !reset_i && aux_any && (!wb_valid_i || force_win);

    sel_addr = wb_grant ? wb_rd_addr_i : aux_addr[pick_idx];
    sel_data = wb_grant ? wb_rd_data_i : aux_data[pick_idx];

    starve_cnt_d = starve_cnt_q;
    if (!aux_any || aux_grant) begin
      starve_cnt_d = '0;
    end else if (wb_grant && (starve_cnt_q != STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    rr_ptr_d = rr_ptr_q;
    if (aux_grant) begin
      rr_ptr_d = (pick_idx == IW'(N_AUX - 1)) ? '0 : pick_idx + 1'b1;
    end

    // Address/data hold on idle cycles; only the enable drops.
    rf_d    = rf_q;
    rf_d.en = 1'b0;
    if (wb_grant || aux_grant) begin
      rf_d.en   = (sel_addr != REG_ZERO);
      rf_d.addr = sel_addr;
      rf_d.data = sel_data;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_ptr_q     <= '0;
      starve_cnt_q <= '0;
      rf_q         <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      rf_q         <= rf_d;
    end
  end

  assign wb_ready_o    = wb_grant;
  assign aux_ready_o   = aux_grant ? pick_gnt : '0;
  assign rf_w_enable_o = rf_q.en;
  assign rf_w_addr_o   = rf_q.addr;
  assign rf_w_data_o   = rf_q.data;
  assign hz_rd_addr_o  = rf_q.en ? rf_q.addr : REG_ZERO;

`ifdef RISCV_WARB_STATS_EN
  logic [31:0] stat_wb_q, stat_wb_d;
  logic [31:0] stat_aux_q, stat_aux_d;
  logic [31:0] stat_force_q, stat_force_d;

  always_comb begin
    stat_wb_d    = stat_wb_q + {31'd0, wb_grant};
    stat_aux_d   = stat_aux_q + {31'd0, aux_grant};
    stat_force_d = stat_force_q + {31'd0, aux_grant && force_win};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stat_wb_q    <= '0;
      stat_aux_q   <= '0;
      stat_force_q <= '0;
    end else begin
      stat_wb_q    <= stat_wb_d;
      stat_aux_q   <= stat_aux_d;
      stat_force_q <= stat_force_d;
    end
  end

  assign stat_wb_cnt_o    = stat_wb_q;
  assign stat_aux_cnt_o   = stat_aux_q;
  assign stat_force_cnt_o = stat_force_q;
`else
  assign stat_wb_cnt_o    = '0;
  assign stat_aux_cnt_o   = '0;
  assign stat_force_cnt_o = '0;
`endif

endmodule

// File: tb/tb_riscv_rf_wr_arb.sv
// Scoreboard bench for riscv_rf_wr_arb: directed scenarios then random traffic.
module tb_riscv_rf_wr_arb;

  localparam int N_AUX      = 2;
  localparam int STARVE_MAX = 4;
  localparam int WBG        = N_AUX;

  logic                clk;
  logic                rst;
  logic                wb_v;
  logic [4:0]          wb_a;
  logic [31:0]         wb_d;
  logic [N_AUX-1:0]    ax_v;
  logic [4:0]          ax_a [N_AUX];
  logic [31:0]         ax_d [N_AUX];
  logic [5*N_AUX-1:0]  ax_a_bus;
  logic [32*N_AUX-1:0] ax_d_bus;

  logic                wb_ready;
  logic [N_AUX-1:0]    aux_ready;
  logic                rf_en;
  logic [4:0]          rf_addr;
  logic [31:0]         rf_data;
  logic [4:0]          hz_addr;
  logic [31:0]         st_wb, st_aux, st_force;

  riscv_rf_wr_arb #(.N_AUX(N_AUX), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i            (clk),
    .reset_i          (rst),
    .wb_valid_i       (wb_v),
    .wb_ready_o       (wb_ready),
    .wb_rd_addr_i     (wb_a),
    .wb_rd_data_i     (wb_d),
    .aux_valid_i      (ax_v),
    .aux_ready_o      (aux_ready),
    .aux_rd_addr_i    (ax_a_bus),
    .aux_rd_data_i    (ax_d_bus),
    .rf_w_enable_o    (rf_en),
    .rf_w_addr_o      (rf_addr),
    .rf_w_data_o      (rf_data),
    .hz_rd_addr_o     (hz_addr),
    .stat_wb_cnt_o    (st_wb),
    .stat_aux_cnt_o   (st_aux),
    .stat_force_cnt_o (st_force)
  );

  always_comb begin
    ax_a_bus = '0;
    ax_d_bus = '0;
    for (int k = 0; k < N_AUX; k++) begin
      ax_a_bus[5*k +: 5]   = ax_a[k];
      ax_d_bus[32*k +: 32] = ax_d[k];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  bit   mon_en;
  int   n_checks;
  int   n_pass;

  // Reference model state
  int          m_rr;
  int          m_starve;
  logic [4:0]  m_last_addr;
  logic [31:0] m_last_data;
  int unsigned m_wb_cnt, m_aux_cnt, m_force_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_stats(input string tag);
`ifdef RISCV_WARB_STATS_EN
    chk({tag, "_stat_wb"},    st_wb,    m_wb_cnt);
    chk({tag, "_stat_aux"},   st_aux,   m_aux_cnt);
    chk({tag, "_stat_force"}, st_force, m_force_cnt);
`else
    chk({tag, "_stat_wb"},    st_wb,    32'd0);
    chk({tag, "_stat_aux"},   st_aux,   32'd0);
    chk({tag, "_stat_force"}, st_force, 32'd0);
`endif
  endtask

  task automatic model_reset();
    m_rr = 0; m_starve = 0;
    m_last_addr = '0; m_last_data = '0;
    m_wb_cnt = 0; m_aux_cnt = 0; m_force_cnt = 0;
  endtask

  // Called just after a negedge with inputs already driven. Checks ready outputs
  // against the model, queues the expected write, then retires accepted sources.
  task automatic step(output int g);
    bit          any, forced, found;
    int          k;
    logic [N_AUX-1:0] exp_aux;
    exp_t        e;
    #1;
    any    = (ax_v != '0);
    forced = any && (m_starve == STARVE_MAX);
    g      = -1;
    if (wb_v && !forced) g = WBG;
    else if (any) begin
      found = 0;
      for (int i = 0; i < N_AUX; i++) begin
        k = (m_rr + i) % N_AUX;
        if (!found && ax_v[k]) begin g = k; found = 1; end
      end
    end
    exp_aux = '0;
    if (g >= 0 && g < N_AUX) exp_aux[g] = 1'b1;
    chk("wb_ready", {31'd0, wb_ready}, {31'd0, g == WBG});
    chk("aux_ready", 32'(aux_ready), 32'(exp_aux));

    if (g == WBG) begin
      m_wb_cnt++;
      if (any) m_starve = (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
      m_last_addr = wb_a; m_last_data = wb_d;
    end else if (g >= 0) begin
      m_aux_cnt++;
      if (forced) m_force_cnt++;
      m_starve = 0;
      m_rr = (g + 1) % N_AUX;
      m_last_addr = ax_a[g]; m_last_data = ax_d[g];
    end else begin
      m_starve = 0;
    end
    e.en   = (g >= 0) && (m_last_addr != 5'd0);
    e.addr = m_last_addr;
    e.data = m_last_data;
    exp_q.push_back(e);
    mon_en = 1'b1;

    @(negedge clk);
    if (g == WBG) wb_v = 1'b0;
    else if (g >= 0) ax_v[g] = 1'b0;
    $display("cycle t=%0t grant=%0d wb_v=%0b aux_v=%b starve=%0d rr=%0d", $time, g, wb_v, ax_v, m_starve, m_rr);
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rf_en",   {31'd0, rf_en}, {31'd0, mon_e.en});
        chk("rf_addr", {27'd0, rf_addr}, {27'd0, mon_e.addr});
        chk("rf_data", rf_data, mon_e.data);
        chk("hz_addr", {27'd0, hz_addr}, {27'd0, (mon_e.en ? mon_e.addr : 5'd0)});
      end
    end
  end

  task automatic set_wb(input logic [4:0] a, input logic [31:0] d);
    wb_v = 1'b1; wb_a = a; wb_d = d;
  endtask

  task automatic set_ax(input int k, input logic [4:0] a, input logic [31:0] d);
    ax_v[k] = 1'b1; ax_a[k] = a; ax_d[k] = d;
  endtask

  int g;

  initial begin
    n_checks = 0; n_pass = 0; mon_en = 1'b0;
    model_reset();
    wb_v = 1'b0; wb_a = '0; wb_d = '0; ax_v = '0;
    for (int k = 0; k < N_AUX; k++) begin ax_a[k] = '0; ax_d[k] = '0; end

    // Reset: outputs clear and nothing is accepted even with valids up
    rst = 1'b1;
    set_wb(5'd3, 32'h33); set_ax(0, 5'd4, 32'h44);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wb_ready", {31'd0, wb_ready}, 32'd0);
    chk("rst_aux_ready", 32'(aux_ready), 32'd0);
    chk("rst_rf_en", {31'd0, rf_en}, 32'd0);
    chk("rst_rf_addr", {27'd0, rf_addr}, 32'd0);
    chk("rst_rf_data", rf_data, 32'd0);
    chk("rst_hz", {27'd0, hz_addr}, 32'd0);
    chk_stats("rst");
    @(negedge clk);
    wb_v = 1'b0; ax_v = '0;
    rst = 1'b0;

    // WB-only back-to-back
    set_wb(5'd5, 32'h11); step(g);
    set_wb(5'd6, 32'h22); step(g);
    step(g); step(g);
    chk_stats("s1");

    // Two aux sources, WB idle
    set_ax(0, 5'd7, 32'hAA); set_ax(1, 5'd8, 32'hBB);
    step(g); step(g); step(g);
    chk_stats("s2");

    // Starvation: WB continuously valid against aux0
    set_ax(0, 5'd11, 32'hCC);
    for (int c = 0; c < 6; c++) begin
      if (!wb_v) set_wb(5'(10 + c), 32'h100 + c);
      step(g);
    end
    wb_v = 1'b0; step(g);
    chk_stats("s3");

    // Write to x0
    set_wb(5'd0, 32'hDEAD); step(g); step(g);

    // Reset right after accepting x9
    set_ax(1, 5'd12, 32'h1212);
    set_wb(5'd13, 32'h1313); step(g);
    set_wb(5'd9, 32'h99); step(g);
    mon_en = 1'b0;
    set_wb(5'd14, 32'h1414);
    rst = 1'b1;
    #1;
    chk("midrst_rf_en", {31'd0, rf_en}, 32'd0);
    chk("midrst_hz", {27'd0, hz_addr}, 32'd0);
    chk("midrst_wb_ready", {31'd0, wb_ready}, 32'd0);
    chk("midrst_aux_ready", 32'(aux_ready), 32'd0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    model_reset();
    wb_v = 1'b0;
    rst = 1'b0;
    chk_stats("midrst");
    set_ax(0, 5'd15, 32'h1515);
    step(g); step(g);
    for (int c = 0; c < 6; c++) begin
      if (!wb_v) set_wb(5'(16 + c), 32'h200 + c);
      if (c == 0) set_ax(1, 5'd22, 32'h2222);
      step(g);
    end
    wb_v = 1'b0; step(g);
    chk_stats("s5");

    // Random traffic; sources hold valid until accepted
    for (int c = 0; c < 400; c++) begin
      if (!wb_v && ($urandom_range(0, 1) == 0)) set_wb(5'($urandom_range(0, 31)), $urandom);
      for (int k = 0; k < N_AUX; k++)
        if (!ax_v[k] && ($urandom_range(0, 9) < 3)) set_ax(k, 5'($urandom_range(0, 31)), $urandom);
      step(g);
    end
    wb_v = 1'b0; ax_v = '0;
    step(g); step(g);
    chk_stats("rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
